// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral and its synchronizer.
package spi_pkg;

  localparam int SPI_WORD_W    = 8;
  localparam int CFG_W         = 3;
  localparam int BIT_CNT_W     = 3;
  localparam int CFG_VALID_BIT = 0;
  localparam int CFG_MODE_LSB  = 1;
  localparam int CFG_MODE_MSB  = 2;

  // mode = {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_e;

  typedef enum logic [1:0] {
    WAIT_CS_HIGH = 2'd0,
    IDLE         = 2'd1,
    ACTIVE       = 2'd2
  } periph_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus one extra flop
// used only to detect rising/falling edges of the synchronized level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // synchronizer chain and edge-detect history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign dout = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI target: byte-wide, modes 0-3, MSB first, single chip select.
// SCLK/CS/COPI are oversampled in the i_clk domain; all decisions use the
// synchronized copies. Optional feature macro: SPI_PERIPHERAL_OVERRUN_EN
// (adds the sticky o_overrun flag and its tracking logic).
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_WORD_W-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CFG_W-1:0]      i_config,
  input  logic [SPI_WORD_W-1:0] i_tx,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [SPI_WORD_W-1:0] o_rx,
  output logic                  o_rx_valid,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_copi,
  output logic                  o_cipo,
  output logic                  o_cipo_en
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  ,
  output logic                  o_overrun
`endif
);

  // synchronized pins and edge strobes
  logic sclk_level_unused_s, sclk_rise_s, sclk_fall_s;
  logic cs_n_s, cs_rise_s, cs_fall_s;
  logic copi_s, copi_rise_unused_s, copi_fall_unused_s;

  // CS sync resets to "asserted" so that a frame in progress at reset
  // release is seen as such and WAIT_CS_HIGH waits for a real deassertion.
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(i_clk), .rst(i_rst), .din(i_sclk),
    .dout(sclk_level_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk(i_clk), .rst(i_rst), .din(i_cs_n),
    .dout(cs_n_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(i_clk), .rst(i_rst), .din(i_copi),
    .dout(copi_s), .rise(copi_rise_unused_s), .fall(copi_fall_unused_s)
  );

  periph_state_e         state_r, state_nxt_s;
  spi_mode_e             mode_r;
  logic [1:0]            mode_bits_s;
  logic                  cpol_s, cpha_s, cfg_valid_s;
  logic                  leading_s, trailing_s, sample_s, shift_s;
  logic                  start_s, abort_s, sample_en_s, shift_en_s, byte_done_s, load_s;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [SPI_WORD_W-1:0] rx_sr_r, rx_r, tx_sr_r, hold_r, load_byte_s;
  logic                  rx_valid_r, hold_full_r, hold_full_nxt_s, tx_ready_r, tx_accept_s;
  logic                  cipo_r, cipo_en_r;

  assign mode_bits_s = mode_r;
  assign cpol_s      = mode_bits_s[1];
  assign cpha_s      = mode_bits_s[0];
  assign cfg_valid_s = i_config[CFG_VALID_BIT];

  // classify SCLK edges into sample / shift according to the latched mode
  always_comb begin
    leading_s  = cpol_s ? sclk_fall_s : sclk_rise_s;
    trailing_s = cpol_s ? sclk_rise_s : sclk_fall_s;
    sample_s   = cpha_s ? trailing_s : leading_s;
    shift_s    = cpha_s ? leading_s : trailing_s;
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= WAIT_CS_HIGH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_CS_HIGH: if (cs_n_s)    state_nxt_s = IDLE;         else state_nxt_s = WAIT_CS_HIGH;
      IDLE:         if (cs_fall_s) state_nxt_s = ACTIVE;       else state_nxt_s = IDLE;
      ACTIVE:       if (cs_rise_s) state_nxt_s = IDLE;         else state_nxt_s = ACTIVE;
      default:                     state_nxt_s = WAIT_CS_HIGH;
    endcase
  end

  // FSM output decode: per-cycle control strobes for the datapath
  always_comb begin
    start_s     = (state_r == IDLE) && cs_fall_s;
    abort_s     = (state_r == ACTIVE) && cs_rise_s;
    sample_en_s = (state_r == ACTIVE) && !cs_rise_s && sample_s;
    shift_en_s  = (state_r == ACTIVE) && !cs_rise_s && shift_s;
    byte_done_s = sample_en_s && (bit_cnt_r == 3'd7);
    load_s      = start_s || byte_done_s;
    load_byte_s = hold_full_r ? hold_r : IDLE_FILL;
  end

  // mode is only changed while no frame is being shifted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_r <= MODE0;
    end else if (cfg_valid_s && (state_r != ACTIVE)) begin
      mode_r <= spi_mode_e'(i_config[CFG_MODE_MSB:CFG_MODE_LSB]);
    end else begin
      mode_r <= mode_r;
    end
  end

  // holding register occupancy; an offer coinciding with a load refills it
  always_comb begin
    tx_accept_s = i_tx_valid && (tx_ready_r || load_s);
    if (tx_accept_s) begin
      hold_full_nxt_s = 1'b1;
    end else if (load_s) begin
      hold_full_nxt_s = 1'b0;
    end else begin
      hold_full_nxt_s = hold_full_r;
    end
  end

  // one-entry reply holding register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      tx_ready_r  <= 1'b1;
    end else begin
      if (tx_accept_s) begin
        hold_r <= i_tx;
      end
      hold_full_r <= hold_full_nxt_s;
      tx_ready_r  <= !hold_full_nxt_s;
    end
  end

  // transmit shifter; CPHA=0 puts the MSB out as soon as CS is seen low,
  // otherwise every bit goes out on a shift edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_sr_r <= 8'h00;
      cipo_r  <= 1'b0;
    end else if (start_s && !cpha_s) begin
      cipo_r  <= load_byte_s[7];
      tx_sr_r <= {load_byte_s[6:0], 1'b0};
    end else if (load_s) begin
      tx_sr_r <= load_byte_s;
    end else if (shift_en_s) begin
      cipo_r  <= tx_sr_r[7];
      tx_sr_r <= {tx_sr_r[6:0], 1'b0};
    end
  end

  // receive shifter, bit counter and received-byte output register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sr_r    <= 8'h00;
      rx_r       <= 8'h00;
      rx_valid_r <= 1'b0;
      bit_cnt_r  <= 3'd0;
    end else begin
      rx_valid_r <= byte_done_s;
      if (start_s || abort_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sample_en_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        rx_sr_r   <= {rx_sr_r[6:0], copi_s};
      end
      if (byte_done_s) begin
        rx_r <= {rx_sr_r[6:0], copi_s};
      end
    end
  end

  // drive the bus only while selected and not waiting out a stale frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cipo_en_r <= 1'b0;
    end else begin
      cipo_en_r <= !cs_n_s && (state_r != WAIT_CS_HIGH);
    end
  end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic tx_fill_r, overrun_r;

  // remember whether the byte currently being shifted out is filler
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_fill_r <= 1'b0;
    end else if (load_s) begin
      tx_fill_r <= !hold_full_r;
    end else begin
      tx_fill_r <= tx_fill_r;
    end
  end

  // sticky error: output pipeline collision or filler byte actually sent
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_r <= 1'b0;
    end else if (cfg_valid_s) begin
      overrun_r <= 1'b0;
    end else if (byte_done_s && (rx_valid_r || tx_fill_r)) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign o_overrun = overrun_r;
`endif

  assign o_tx_ready = tx_ready_r;
  assign o_rx       = rx_r;
  assign o_rx_valid = rx_valid_r;
  assign o_cipo     = cipo_r;
  assign o_cipo_en  = cipo_en_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral; the SPI controller side is modelled by
// tasks driving SCLK/CS/COPI with 4 i_clk cycles per SCLK phase.
`timescale 1ns/1ps
module tb_spi_peripheral;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cfg;
  logic [7:0] tx;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx;
  logic       rx_valid;
  logic       sclk, cs_n, copi, cipo, cipo_en;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic       overrun;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulse_cnt = 0;
  logic [7:0] last_rx = 8'h00;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;

  always #5 clk = ~clk;

  spi_peripheral dut (
    .i_clk(clk), .i_rst(rst), .i_config(cfg),
    .i_tx(tx), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx(rx), .o_rx_valid(rx_valid),
    .i_sclk(sclk), .i_cs_n(cs_n), .i_copi(copi),
    .o_cipo(cipo), .o_cipo_en(cipo_en)
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    , .o_overrun(overrun)
`endif
  );

  // count received-byte pulses and capture the byte they carry
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      last_rx   <= rx;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk); cfg = {m, 1'b1};
    @(negedge clk); cfg = 3'b000;
    cpol = m[1]; cpha = m[0];
  endtask

  task automatic queue_tx(input logic [7:0] b);
    int k;
    tx = b; tx_valid = 1'b1; k = 0;
    while (tx_ready !== 1'b1 && k < 50) begin wait_cyc(1); k++; end
    if (k >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL queue_timeout: tx_ready=%b, required 1", tx_ready);
    end
    wait_cyc(1);
    tx_valid = 1'b0;
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_drop: got %b, expected 0", tx_ready); end
  endtask

  task automatic spi_begin();
    sclk = cpol; wait_cyc(HALF); cs_n = 1'b0;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    r = 1'b0;
    if (!cpha) copi = b;
    wait_cyc(HALF);
    if (!cpha) r = cipo;
    sclk = ~cpol;
    if (cpha) copi = b;
    wait_cyc(HALF);
    if (cpha) r = cipo;
    sclk = cpol;
  endtask

  task automatic spi_end();
    wait_cyc(HALF); cs_n = 1'b1; wait_cyc(2 * HALF);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, output logic [7:0] mi);
    logic bi;
    mi = 8'h00;
    spi_begin();
    for (int i = 7; i >= 0; i--) begin spi_bit(mo[i], bi); mi[i] = bi; end
    spi_end();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg = 3'b000; tx = 8'h00; tx_valid = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; copi = 1'b0;
    wait_cyc(3);
    n_checks++; if (tx_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_tx_ready: got %b, expected 1", tx_ready); end
    n_checks++; if (rx !== 8'h00)       begin n_fail++; $display("FAIL rst_rx: got %h, expected 00", rx); end
    n_checks++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_rx_valid: got %b, expected 0", rx_valid); end
    n_checks++; if (cipo !== 1'b0)      begin n_fail++; $display("FAIL rst_cipo: got %b, expected 0", cipo); end
    n_checks++; if (cipo_en !== 1'b0)   begin n_fail++; $display("FAIL rst_cipo_en: got %b, expected 0", cipo_en); end
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    n_checks++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
`endif
    rst = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_mode0_basic();
    logic [7:0] got; int p0;
    set_mode(2'd0);
    queue_tx(8'hA5);
    p0 = pulse_cnt;
    spi_xfer(8'h3C, got);
    n_checks++; if (got !== 8'hA5)          begin n_fail++; $display("FAIL m0_cipo_byte: got %h, expected a5", got); end
    n_checks++; if (last_rx !== 8'h3C)      begin n_fail++; $display("FAIL m0_rx_byte: got %h, expected 3c", last_rx); end
    n_checks++; if (pulse_cnt - p0 != 1)    begin n_fail++; $display("FAIL m0_pulses: got %0d, expected 1", pulse_cnt - p0); end
    n_checks++; if (tx_ready !== 1'b1)      begin n_fail++; $display("FAIL m0_tx_ready_back: got %b, expected 1", tx_ready); end
    n_checks++; if (cipo_en !== 1'b0)       begin n_fail++; $display("FAIL m0_cipo_en_idle: got %b, expected 0", cipo_en); end
  endtask

  task automatic test_idle_fill();
    logic [7:0] got; int p0;
    p0 = pulse_cnt;
    spi_xfer(8'h00, got);
    n_checks++; if (got !== 8'hFF)          begin n_fail++; $display("FAIL fill_byte: got %h, expected ff", got); end
    n_checks++; if (last_rx !== 8'h00)      begin n_fail++; $display("FAIL fill_rx: got %h, expected 00", last_rx); end
    n_checks++; if (pulse_cnt - p0 != 1)    begin n_fail++; $display("FAIL fill_pulses: got %0d, expected 1", pulse_cnt - p0); end
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    n_checks++; if (overrun !== 1'b1)       begin n_fail++; $display("FAIL fill_overrun: got %b, expected 1", overrun); end
`endif
  endtask

  task automatic test_partial_frame();
    logic [7:0] got; logic bi; int p0;
    p0 = pulse_cnt;
    spi_begin();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, bi);
    spi_end();
    n_checks++; if (pulse_cnt != p0)        begin n_fail++; $display("FAIL partial_no_pulse: got %0d, expected 0", pulse_cnt - p0); end
    queue_tx(8'h42);
    spi_xfer(8'h81, got);
    n_checks++; if (got !== 8'h42)          begin n_fail++; $display("FAIL partial_next_tx: got %h, expected 42", got); end
    n_checks++; if (last_rx !== 8'h81)      begin n_fail++; $display("FAIL partial_next_rx: got %h, expected 81", last_rx); end
    n_checks++; if (pulse_cnt - p0 != 1)    begin n_fail++; $display("FAIL partial_next_pulses: got %0d, expected 1", pulse_cnt - p0); end
  endtask

  task automatic test_cfg_gating();
    logic [7:0] got; logic [7:0] mo; logic bi;
    mo = 8'hC3; got = 8'h00;
    queue_tx(8'h5A);
    spi_begin();
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin cfg = 3'b111; wait_cyc(1); cfg = 3'b000; end
      spi_bit(mo[i], bi); got[i] = bi;
    end
    spi_end();
    n_checks++; if (got !== 8'h5A)          begin n_fail++; $display("FAIL cfg_active_tx: got %h, expected 5a", got); end
    n_checks++; if (last_rx !== 8'hC3)      begin n_fail++; $display("FAIL cfg_active_rx: got %h, expected c3", last_rx); end
    set_mode(2'd3);
    queue_tx(8'h96);
    spi_xfer(8'h69, got);
    n_checks++; if (got !== 8'h96)          begin n_fail++; $display("FAIL cfg_idle_m3_tx: got %h, expected 96", got); end
    n_checks++; if (last_rx !== 8'h69)      begin n_fail++; $display("FAIL cfg_idle_m3_rx: got %h, expected 69", last_rx); end
  endtask

  task automatic test_modes_random();
    logic [7:0] a, b, got; int p0;
    for (int m = 1; m <= 3; m++) begin
      set_mode(2'(m));
      for (int n = 0; n < 255; n++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        queue_tx(b);
        p0 = pulse_cnt;
        spi_xfer(a, got);
        n_checks++; if (got !== b)           begin n_fail++; $display("FAIL rand_m%0d_tx #%0d: got %h, expected %h", m, n, got, b); end
        n_checks++; if (last_rx !== a)       begin n_fail++; $display("FAIL rand_m%0d_rx #%0d: got %h, expected %h", m, n, last_rx, a); end
        n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL rand_m%0d_pulses #%0d: got %0d, expected 1", m, n, pulse_cnt - p0); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got; logic [7:0] mo; logic bi; int p0;
    set_mode(2'd0);
    queue_tx(8'hE7);
    mo = 8'hAA;
    spi_begin();
    for (int i = 7; i >= 5; i--) spi_bit(mo[i], bi);
    rst = 1'b1;
    wait_cyc(2);
    n_checks++; if (tx_ready !== 1'b1)      begin n_fail++; $display("FAIL midrst_tx_ready: got %b, expected 1", tx_ready); end
    n_checks++; if (rx !== 8'h00)           begin n_fail++; $display("FAIL midrst_rx: got %h, expected 00", rx); end
    n_checks++; if (rx_valid !== 1'b0)      begin n_fail++; $display("FAIL midrst_rx_valid: got %b, expected 0", rx_valid); end
    n_checks++; if (cipo !== 1'b0)          begin n_fail++; $display("FAIL midrst_cipo: got %b, expected 0", cipo); end
    n_checks++; if (cipo_en !== 1'b0)       begin n_fail++; $display("FAIL midrst_cipo_en: got %b, expected 0", cipo_en); end
    rst = 1'b0;
    cpol = 1'b0; cpha = 1'b0;
    p0 = pulse_cnt;
    for (int i = 4; i >= 0; i--) spi_bit(mo[i], bi);
    n_checks++; if (cipo_en !== 1'b0)       begin n_fail++; $display("FAIL midrst_stale_cipo_en: got %b, expected 0", cipo_en); end
    spi_end();
    n_checks++; if (pulse_cnt != p0)        begin n_fail++; $display("FAIL midrst_stale_pulse: got %0d, expected 0", pulse_cnt - p0); end
    queue_tx(8'h3A);
    spi_xfer(8'h5C, got);
    n_checks++; if (got !== 8'h3A)          begin n_fail++; $display("FAIL midrst_next_tx: got %h, expected 3a", got); end
    n_checks++; if (last_rx !== 8'h5C)      begin n_fail++; $display("FAIL midrst_next_rx: got %h, expected 5c", last_rx); end
    n_checks++; if (pulse_cnt - p0 != 1)    begin n_fail++; $display("FAIL midrst_next_pulses: got %0d, expected 1", pulse_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_idle_fill();
    test_partial_frame();
    test_cfg_gating();
    test_modes_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
